dfc_gen: RTL and testbench

Parametrised data-format/compute engine, the next generation of the fixed 8-word DFC.
- Loads an N-word buffer through a byte-serial command interface.
- Executes buffer commands, each streaming a sequence of (DW+1)-bit results with output_valid.
- Adds configurable width and depth, a 3-bit opcode, and in-place rotate and max/min modes.

---
 rtl/dfc_gen.sv | 117 +++++++++++
 tb/tb_dfc_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dfc_gen.sv
// Parametrised data-format/compute engine: byte-serial buffer load, then
// streaming commands (raw, pair-sum, reverse, max/min) and in-place rotate.
module dfc_gen #(
  parameter int DW    = 8,
  parameter int N     = 8,
  parameter int CNT_W = $clog2(N+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] datain,
  input  logic [2:0]    cmd,
  input  logic          cmd_valid,
  output logic [DW:0]   dataout,
  output logic          output_valid,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, ROT} state_t;

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_t            state;
  logic [2:0]        op_q;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  k;
  logic [DW-1:0]     mem [N];
  logic [DW-1:0]     mx, mn;
  logic [DW:0]       res;
  logic [IW-1:0]     ia, ib, ir;

  // Max/min are combinational over the whole buffer, so MAXMIN streams like RAW.
  always_comb begin
    mx = '0;
    mn = '1;
    for (int unsigned i = 0; i < N; i++) begin
      if (mem[IW'(i)] > mx) mx = mem[IW'(i)];
      if (mem[IW'(i)] < mn) mn = mem[IW'(i)];
    end
  end

  always_comb begin
    case (op_q)
      3'd2:    k = CNT_W'(N - 1);
      3'd5:    k = CNT_W'(2);
      default: k = CNT_W'(N);
    endcase
  end

  always_comb begin
    ia  = IW'(cnt);
    ib  = IW'(cnt + 1'b1);
    ir  = IW'(CNT_W'(N - 1) - cnt);
    res = '0;
    case (op_q)
      3'd1:    res = {1'b0, mem[ia]};
      3'd2:    res = {1'b0, mem[ia]} + {1'b0, mem[ib]};
      3'd3:    res = {1'b0, mem[ir]};
      3'd5:    res = {1'b0, (cnt == '0) ? mx : mn};
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      op_q         <= '0;
      cnt          <= '0;
      dataout      <= '0;
      output_valid <= 1'b0;
      busy         <= 1'b0;
      for (int unsigned i = 0; i < N; i++) mem[IW'(i)] <= '0;
    end else begin
      case (state)
        IDLE: begin
          output_valid <= 1'b0;
          if (cmd_valid && cmd <= 3'd5) begin
            op_q <= cmd;
            cnt  <= '0;
            busy <= 1'b1;
            case (cmd)
              3'd0:    state <= LOAD;
              3'd4:    state <= ROT;
              default: state <= STREAM;
            endcase
          end
        end
        LOAD: begin
          mem[IW'(cnt)] <= datain;
          cnt           <= cnt + 1'b1;
          if (cnt == CNT_W'(N - 1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        STREAM: begin
          if (cnt == k) begin
            output_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end else begin
            dataout      <= res;
            output_valid <= 1'b1;
            cnt          <= cnt + 1'b1;
          end
        end
        ROT: begin
          for (int unsigned i = 0; i < N - 1; i++) mem[IW'(i)] <= mem[IW'(i + 1)];
          mem[IW'(N - 1)] <= mem[0];
          busy            <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dfc_gen.sv
// Directed plus randomized bench for dfc_gen against a word-array reference model.
module tb_dfc_gen;
  localparam int DW = 8;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] datain;
  logic [2:0]    cmd;
  logic          cmd_valid;
  logic [DW:0]   dataout;
  logic          output_valid;
  logic          busy;

  int passed = 0;
  int total  = 0;
  int unsigned model [N];
  logic [DW-1:0] ld [N];
  int unsigned exp_q [$];

  dfc_gen #(.DW(DW), .N(N)) dut (
    .clk(clk), .reset(reset), .datain(datain), .cmd(cmd), .cmd_valid(cmd_valid),
    .dataout(dataout), .output_valid(output_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic void build_exp(input logic [2:0] op);
    int unsigned s [$];
    exp_q.delete();
    case (op)
      3'd1: for (int i = 0; i < N; i++) exp_q.push_back(model[i]);
      3'd2: for (int i = 0; i < N - 1; i++) exp_q.push_back(model[i] + model[i+1]);
      3'd3: for (int i = 0; i < N; i++) exp_q.push_back(model[N-1-i]);
      3'd5: begin
        for (int i = 0; i < N; i++) s.push_back(model[i]);
        s.sort();
        exp_q.push_back(s[$]);
        exp_q.push_back(s[0]);
      end
      default: ;
    endcase
  endfunction

  task automatic do_load(input string tag);
    @(negedge clk); cmd = 3'd0; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); cmd_valid = 1'b0;
    check({tag, "_busy_t0"}, busy, 1);
    for (int i = 0; i < N; i++) begin
      datain = ld[i];
      @(posedge clk);
      @(negedge clk);
    end
    check({tag, "_busy_done"}, busy, 0);
    check({tag, "_no_valid"}, output_valid, 0);
    for (int i = 0; i < N; i++) model[i] = ld[i];
  endtask

  task automatic do_rotl(input string tag);
    int unsigned first;
    @(negedge clk); cmd = 3'd4; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); cmd_valid = 1'b0;
    check({tag, "_busy_t0"}, busy, 1);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_busy_t1"}, busy, 0);
    check({tag, "_no_valid"}, output_valid, 0);
    first = model[0];
    for (int i = 0; i < N - 1; i++) model[i] = model[i+1];
    model[N-1] = first;
  endtask

  // abort_after > 0 asserts reset right after that many outputs were seen.
  task automatic do_stream(input logic [2:0] op, input bit inject, input int abort_after,
                           input string tag);
    int count = 0;
    int first = -1;
    int blow  = -1;
    build_exp(op);
    @(negedge clk); cmd = op; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); cmd_valid = 1'b0;
    check({tag, "_busy_t0"}, busy, 1);
    check({tag, "_valid_t0"}, output_valid, 0);
    for (int cyc = 0; cyc < 2 * N + 6; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      cmd_valid = inject && (cyc == 2);
      cmd = 3'd1;
      if (output_valid) begin
        if (first < 0) first = cyc;
        check({tag, "_contig"}, cyc, first + count);
        if (count < exp_q.size()) check({tag, "_data"}, dataout, exp_q[count]);
        count++;
        if (abort_after > 0 && count == abort_after) begin
          cmd_valid = 1'b0;
          reset = 1'b1;
          @(posedge clk);
          @(negedge clk);
          check({tag, "_abort_valid"}, output_valid, 0);
          check({tag, "_abort_busy"}, busy, 0);
          reset = 1'b0;
          for (int i = 0; i < N; i++) model[i] = 0;
          return;
        end
      end
      if (!busy && blow < 0) blow = cyc;
    end
    cmd_valid = 1'b0;
    check({tag, "_count"}, count, exp_q.size());
    check({tag, "_latency"}, (op == 3'd5) ? (first >= 0 && first <= N + 1) : (first == 0), 1);
    check({tag, "_busy_fall"}, blow, first + exp_q.size());
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd = '0; datain = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", output_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_dataout", dataout, 0);
    reset = 1'b0;
    for (int i = 0; i < N; i++) model[i] = 0;

    do_stream(3'd1, 1'b0, 0, "raw_unloaded");

    for (int i = 0; i < N; i++) ld[i] = DW'(i + 1);
    do_load("load_inc");
    do_stream(3'd1, 1'b0, 0, "raw_inc");
    do_stream(3'd2, 1'b0, 0, "pairsum_inc");

    for (int i = 0; i < N; i++) ld[i] = '1;
    do_load("load_ff");
    do_stream(3'd2, 1'b0, 0, "pairsum_ff");

    for (int i = 0; i < N; i++) ld[i] = DW'(i + 1);
    do_load("load_inc2");
    do_stream(3'd3, 1'b0, 0, "reverse");
    do_rotl("rotl");
    do_stream(3'd1, 1'b0, 0, "raw_rot");

    ld[0] = 8'h5A; ld[1] = 8'h03; ld[2] = 8'hC7; ld[3] = 8'h10;
    ld[4] = 8'hFF; ld[5] = 8'h00; ld[6] = 8'h81; ld[7] = 8'h22;
    do_load("load_mix");
    do_stream(3'd5, 1'b0, 0, "maxmin");
    do_stream(3'd1, 1'b1, 0, "raw_inject");

    @(negedge clk); cmd = 3'd6; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); cmd_valid = 1'b0;
    check("op6_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("op6_no_valid", output_valid, 0);
    end

    do_stream(3'd1, 1'b0, 3, "raw_abort");
    do_stream(3'd1, 1'b0, 0, "raw_after_reset");

    for (int it = 0; it < 8; it++) begin
      logic [2:0] op;
      for (int i = 0; i < N; i++) ld[i] = DW'($urandom);
      do_load("rnd_load");
      op = 3'($urandom_range(1, 5));
      if (op == 3'd4) begin
        do_rotl("rnd_rotl");
        do_stream(3'd1, 1'b0, 0, "rnd_raw_rot");
      end else begin
        do_stream(op, 1'b0, 0, "rnd_stream");
      end
      do_stream(3'd5, 1'b0, 0, "rnd_maxmin");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
